// File: rtl/truth_table_sweeper.sv
// Purpose: walks every input vector of a small combinational benchmark, samples its outputs and builds the truth table.
// Latency: each vector is held SETTLE cycles, then offered on res_*; a sweep lasts 2^N_IN*(SETTLE+1) cycles with no stalls.
// Backpressure: res_valid/res_* are held for as long as res_ready is low; the sweep stalls and nothing is dropped or repeated.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 18,
    parameter int SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [N_IN-1:0]               dut_x,
    input  logic [N_OUT-1:0]              dut_f,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [N_IN-1:0]               res_vec,
    output logic [N_OUT-1:0]              res_f,
    output logic [N_OUT*(2**N_IN)-1:0]    tt
);

    localparam int              NV        = 2 ** N_IN;
    localparam int              TTW       = N_OUT * NV;
    localparam logic [7:0]      SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [N_IN-1:0]   dut_x_q,   dut_x_d;
    logic [N_IN-1:0]   res_vec_q, res_vec_d;
    logic [N_OUT-1:0]  res_f_q,   res_f_d;
    logic [TTW-1:0]    tt_q,      tt_d;
    logic [7:0]        cnt_q,     cnt_d;

    // Next-state logic: abort overrides everything and freezes all data state.
    always_comb begin
        state_d   = state_q;
        dut_x_d   = dut_x_q;
        res_vec_d = res_vec_q;
        res_f_d   = res_f_q;
        tt_d      = tt_q;
        cnt_d     = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_APPLY;
                        dut_x_d = '0;
                        cnt_d   = SETTLE_M1;
                        tt_d    = '0;
                    end
                end
                S_APPLY: begin
                    if (cnt_q == 8'd0) begin
                        // Settle time elapsed: sample the benchmark and file it under this vector.
                        res_f_d   = dut_f;
                        res_vec_d = dut_x_q;
                        for (int o = 0; o < N_OUT; o++) begin
                            tt_d[o*NV + int'(dut_x_q)] = dut_f[o];
                        end
                        state_d = S_EMIT;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        if (dut_x_q == LAST_VEC) begin
                            state_d = S_DONE;
                        end else begin
                            dut_x_d = dut_x_q + VEC_ONE;
                            cnt_d   = SETTLE_M1;
                            state_d = S_APPLY;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dut_x_q   <= '0;
            res_vec_q <= '0;
            res_f_q   <= '0;
            tt_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dut_x_q   <= dut_x_d;
            res_vec_q <= res_vec_d;
            res_f_q   <= res_f_d;
            tt_q      <= tt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy      = (state_q == S_APPLY) || (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign res_valid = (state_q == S_EMIT);
    assign dut_x     = dut_x_q;
    assign res_vec   = res_vec_q;
    assign res_f     = res_f_q;
    assign tt        = tt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: drives two sweepers (SETTLE=1 and SETTLE=3) against a modelled benchmark and checks every result.
// Latency: checks done timing, settle length per vector, ordering, tt contents, abort and reset behaviour.
// Backpressure: res_ready is driven fixed-high, with a targeted 5-cycle stall, and randomly.
module tb_truth_table_sweeper;

    localparam int N_IN  = 2;
    localparam int N_OUT = 18;
    localparam int NV    = 4;
    localparam int TTW   = N_OUT * NV;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             res_ready;
    logic             busy      [2];
    logic             done      [2];
    logic             res_valid [2];
    logic [N_IN-1:0]  dut_x     [2];
    logic [N_IN-1:0]  res_vec   [2];
    logic [N_OUT-1:0] dut_f     [2];
    logic [N_OUT-1:0] res_f     [2];
    logic [TTW-1:0]   tt        [2];

    logic [N_OUT-1:0] rand_tbl [NV];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Benchmark: four fixed functions, remaining outputs from a per-vector random table.
    function automatic logic [N_OUT-1:0] bench_f(input logic [1:0] x, input logic [N_OUT-1:0] r);
        logic [N_OUT-1:0] f;
        f     = r;
        f[0]  = ~(x[0] & x[1]);
        f[4]  = ~(x[0] ^ x[1]);
        f[10] = x[0];
        f[14] = ~x[1];
        return f;
    endfunction

    assign dut_f[0] = bench_f(dut_x[0], rand_tbl[dut_x[0]]);
    assign dut_f[1] = bench_f(dut_x[1], rand_tbl[dut_x[1]]);

    truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy[0]), .done(done[0]), .dut_x(dut_x[0]), .dut_f(dut_f[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready),
        .res_vec(res_vec[0]), .res_f(res_f[0]), .tt(tt[0])
    );

    truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy[1]), .done(done[1]), .dut_x(dut_x[1]), .dut_f(dut_f[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready),
        .res_vec(res_vec[1]), .res_f(res_f[1]), .tt(tt[1])
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Monitor state: reference truth table and expected next vector per instance.
    logic [TTW-1:0]   m_tt      [2];
    int               exp_vec   [2];
    int               hs        [2];
    int               apply_cnt [2];
    logic             prev_busy [2];
    logic             prev_valid[2];
    logic             prev_stall[2];
    logic             prev_abort;
    logic [N_IN-1:0]  last_vec  [2];
    logic [N_OUT-1:0] last_f    [2];

    // Scoreboard: order, settle length, sampled values and stall stability of every result.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_tt[i] = '0; exp_vec[i] = 0; hs[i] = 0; apply_cnt[i] = 0;
                prev_busy[i] = 1'b0; prev_valid[i] = 1'b0; prev_stall[i] = 1'b0;
            end else begin
                logic [N_OUT-1:0] ef;
                if (busy[i] && !prev_busy[i]) begin
                    m_tt[i] = '0; exp_vec[i] = 0; hs[i] = 0; apply_cnt[i] = 0;
                end
                if (busy[i] && !res_valid[i]) apply_cnt[i]++;
                if (res_valid[i] && !prev_valid[i]) begin
                    ef = bench_f(exp_vec[i][1:0], rand_tbl[exp_vec[i]]);
                    chk("settle_cycles", apply_cnt[i], (i == 0) ? 1 : 3);
                    chk("res_vec", res_vec[i], exp_vec[i]);
                    chk("res_f", res_f[i], ef);
                    for (int o = 0; o < N_OUT; o++) m_tt[i][o*NV + exp_vec[i]] = ef[o];
                    apply_cnt[i] = 0;
                end
                if (prev_stall[i] && !prev_abort) begin
                    chk("stall_valid", res_valid[i], 1'b1);
                    chk("stall_vec", res_vec[i], last_vec[i]);
                    chk("stall_f", res_f[i], last_f[i]);
                end
                if (res_valid[i] && res_ready) begin
                    hs[i]++;
                    exp_vec[i]++;
                end
                prev_stall[i] = res_valid[i] && !res_ready;
                prev_busy[i]  = busy[i];
                prev_valid[i] = res_valid[i];
                last_vec[i]   = res_vec[i];
                last_f[i]     = res_f[i];
            end
        end
        prev_abort = abort;
    end

    int dcyc [2];
    int dcnt [2];

    // mode 0: ready high; 1: 5-cycle stall on vector 2; 2: random ready. extra_start pulses start mid-sweep.
    task automatic sweep(input int mode, input int extra_start);
        int hold = 0;
        dcyc[0] = -1; dcyc[1] = -1; dcnt[0] = 0; dcnt[1] = 0;
        res_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    dcnt[i]++;
                    if (dcyc[i] < 0) dcyc[i] = c;
                end
            end
            if (dcyc[0] >= 0 && dcyc[1] >= 0 && c > dcyc[0] + 3 && c > dcyc[1] + 3) break;
            @(posedge clk); #1;
            start = (c == extra_start);
            case (mode)
                1: begin
                    if (res_valid[0] && res_vec[0] == 2'd2 && hold < 5) begin
                        res_ready = 1'b0; hold++;
                    end else res_ready = 1'b1;
                end
                2:       res_ready = ($urandom_range(0, 99) >= 40);
                default: res_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic check_sweep(input bit timed);
        for (int i = 0; i < 2; i++) begin
            chk("handshakes", hs[i], 4);
            chk("done_pulses", dcnt[i], 1);
            chk("dut_x_after_done", dut_x[i], 2'd3);
            chk("tt_vs_model", tt[i], m_tt[i]);
            if (timed) chk("done_cycle", dcyc[i], (i == 0) ? 8 : 16);
        end
        chk("tt_f1", tt[0][3:0], 4'b0111);
        chk("tt_f5", tt[0][19:16], 4'b1001);
        chk("tt_f11", tt[0][43:40], 4'b1010);
        chk("tt_f15", tt[0][59:56], 4'b0011);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_busy"}, busy[i], 1'b0);
            chk({tag, "_done"}, done[i], 1'b0);
            chk({tag, "_valid"}, res_valid[i], 1'b0);
            chk({tag, "_dut_x"}, dut_x[i], '0);
            chk({tag, "_res_vec"}, res_vec[i], '0);
            chk({tag, "_res_f"}, res_f[i], '0);
            chk({tag, "_tt"}, tt[i], '0);
        end
    endtask

    initial begin
        logic [TTW-1:0]   e_tt;
        logic [N_OUT-1:0] ef;
        bit               found;
        start = 1'b0; abort = 1'b0; res_ready = 1'b1; rst_n = 1'b0;
        for (int v = 0; v < NV; v++) rand_tbl[v] = N_OUT'($urandom);
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk); #1 rst_n = 1'b1;

        sweep(0, -1);  check_sweep(1'b1);
        sweep(1, -1);  check_sweep(1'b0);
        sweep(0, 3);   check_sweep(1'b1);
        for (int v = 0; v < NV; v++) rand_tbl[v] = N_OUT'($urandom);
        sweep(2, -1);  check_sweep(1'b0);

        // Abort while vector 1 of the SETTLE=1 sweeper sits in EMIT.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            res_ready = (dut_x[0] != 2'd1);
            if (res_valid[0] && res_vec[0] == 2'd1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_reached_emit1", found, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; res_ready = 1'b1;
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_valid", res_valid[0], 1'b0);
        chk("abort_dut_x", dut_x[0], 2'd1);
        e_tt = '0;
        for (int v = 0; v < 2; v++) begin
            ef = bench_f(v[1:0], rand_tbl[v]);
            for (int o = 0; o < N_OUT; o++) e_tt[o*NV + v] = ef[o];
        end
        chk("abort_tt_partial", tt[0], e_tt);
        found = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done[0] || done[1]) found = 1'b1;
        end
        chk("abort_no_done", found, 1'b0);

        // Reset during APPLY of vector 2.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (busy[0] && !res_valid[0] && dut_x[0] == 2'd2) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("reset_reached_apply2", found, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk); #1 rst_n = 1'b1;
        sweep(0, -1);  check_sweep(1'b1);

        // start and abort together in IDLE.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("start_abort_busy", busy[0] | busy[1], 1'b0);
            chk("start_abort_valid", res_valid[0] | res_valid[1], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises a small combinational benchmark (N_IN inputs, N_OUT outputs) under test.
- Walks every input vector in ascending order, waits a programmable settle time, then samples the outputs.
- Streams each sampled response over a valid/ready port and accumulates a full truth table for signature comparison against synthesized/balanced variants.
- Sits between the benchmark instance and the checking/collection logic.

Parameters:
- N_IN, 2, number of benchmark inputs; vectors 0..2^N_IN-1.
- N_OUT, 18, number of benchmark outputs.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no done pulse.
- busy  output  1  high in APPLY and EMIT.
- done  output  1  one-cycle pulse after the last vector is accepted.
- dut_x  output  N_IN  vector driven to the benchmark; bit0 = x0.
- dut_f  input  N_OUT  benchmark outputs; bit0 = f1.
- res_valid  output  1  sampled result available.
- res_ready  input  1  consumer accepts the result.
- res_vec  output  N_IN  vector index of the current result.
- res_f  output  N_OUT  sampled dut_f for res_vec.
- tt  output  N_OUT*2^N_IN  truth table; tt[o*2^N_IN+v] = f(o+1) at vector v.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; dut_x, res_vec, res_f, tt = 0; busy, done, res_valid = 0; settle counter = 0.
- States: IDLE, APPLY, EMIT, DONE.
- IDLE:
  - start=1 -> APPLY; dut_x=0; counter=SETTLE-1; tt cleared to 0.
  - start while not in IDLE is ignored.
- APPLY:
  - dut_x held stable.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture dut_f into res_f and into tt column dut_x; res_vec=dut_x; go to EMIT.
  - APPLY lasts exactly SETTLE cycles.
- EMIT:
  - res_valid=1; res_vec, res_f, dut_x held until handshake.
  - On res_valid&res_ready:
    - If dut_x = 2^N_IN-1 -> DONE.
    - Else dut_x increments by 1, counter=SETTLE-1, go to APPLY.
  - res_valid drops the cycle after the handshake.
  - Backpressure of any length is allowed; no result is lost or duplicated.
- DONE: done=1 for exactly one cycle; busy=0; next state IDLE. tt holds until the next accepted start or reset.
- Timing (res_ready=1, SETTLE=S): start sampled at edge k, first APPLY cycle is k+1, done high in cycle k+1+2^N_IN*(S+1).
- dut_x wrap: never wraps mid-sweep; returns to 0 only on a new start or reset. Stays at the last vector after DONE.
- abort:
  - Has priority over all transitions in any state.
  - Next state IDLE; res_valid=0; busy=0; no done.
  - tt keeps partial contents; dut_x keeps its value.
  - abort and start together in IDLE: abort wins.
- Reset mid-sweep: immediate return to reset values, including tt=0.
- SETTLE=1: APPLY is one cycle; sampling occurs on the edge ending that cycle.

Test Plan:
- Benchmark model f1=~(x0&x1), f5=~(x0^x1), f11=x0, f15=~x1; SETTLE=1, res_ready=1; pulse start -> 4 results with res_vec 0,1,2,3; done 9 cycles after start; tt[3:0]=4'b0111, tt[4*4+3:4*4]=4'b1001, tt[10*4+3:10*4]=4'b1010, tt[14*4+3:14*4]=4'b0011.
- SETTLE=3 with res_ready=1 -> each dut_x held 3 cycles before res_valid; done 17 cycles after start.
- res_ready low for 5 cycles on vector 2 -> res_valid, res_vec=2 and res_f held stable throughout; exactly 4 handshakes total; tt unchanged versus the first scenario.
- start pulsed while busy -> ignored, sweep completes normally; abort during EMIT of vector 1 -> IDLE next cycle, no done, tt bits for vectors 0,1 retained, busy=0.
- rst_n asserted during APPLY of vector 2 -> all outputs 0 asynchronously; after release a new start produces a full, correct sweep.
- start and abort high together in IDLE -> remains IDLE, busy=0, no result emitted.
